// File: rtl/ds_capture_buffer.sv
// Triggered snapshot buffer: circular pre-trigger history, level-crossing trigger, post-fill, frozen readout.
// Optional macro CAPTURE_FORCE_TRIG_EN adds a force_trig input that forces the next valid sample to trigger.
module ds_capture_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     arm,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     trig_rising,
  input  logic [DEPTH_LOG2-1:0]    pretrig_len,
`ifdef CAPTURE_FORCE_TRIG_EN
  input  logic                     force_trig,
`endif
  input  logic [DEPTH_LOG2-1:0]    rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [2:0]               state,
  output logic                     done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRETRIG   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POSTTRIG  = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]     start_ptr_q, start_ptr_d;
  logic [DEPTH_LOG2-1:0]     trig_addr_q, trig_addr_d;
  logic [DEPTH_LOG2-1:0]     pre_len_q, pre_len_d;
  logic [DEPTH_LOG2-1:0]     cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]     post_cnt_q, post_cnt_d;
  logic signed [DATA_W-1:0]  prev_q, prev_d;
  logic                      prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]         rd_data_q;
`ifdef CAPTURE_FORCE_TRIG_EN
  logic                      pend_q, pend_d;
`endif

  logic                      capturing;
  logic                      wr_en;
  logic                      level_hit;
  logic                      trig_hit;
  logic [DEPTH_LOG2-1:0]     cnt_inc;
  logic [DEPTH_LOG2-1:0]     post_init;
  logic [DEPTH_LOG2-1:0]     rd_phys;

  logic [DATA_W-1:0] mem [DEPTH];

  assign capturing = (state_q == S_PRETRIG) || (state_q == S_WAIT_TRIG) ||
                     (state_q == S_POSTTRIG);

  // Crossing uses the previously written sample, so invalid gaps never disturb it.
  assign level_hit = prev_valid_q &&
                     (trig_rising ? ((prev_q < trig_level) && (sample_in >= trig_level))
                                  : ((prev_q > trig_level) && (sample_in <= trig_level)));

`ifdef CAPTURE_FORCE_TRIG_EN
  assign trig_hit = level_hit || pend_q;
`else
  assign trig_hit = level_hit;
`endif

  assign rd_phys = start_ptr_q + rd_addr;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    trig_addr_d  = trig_addr_q;
    pre_len_d    = pre_len_q;
    cnt_d        = cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en        = 1'b0;
    cnt_inc      = cnt_q + 1'b1;
    post_init    = LAST_IDX - pre_len_q;
`ifdef CAPTURE_FORCE_TRIG_EN
    pend_d       = pend_q;
`endif

    if (capturing && sample_valid) begin
      wr_en        = 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = sample_in;
      prev_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm && !abort) begin
          // The port width already bounds pretrig_len to DEPTH-1.
          pre_len_d    = pretrig_len;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
`ifdef CAPTURE_FORCE_TRIG_EN
          pend_d       = 1'b0;
`endif
          state_d      = (pretrig_len == '0) ? S_WAIT_TRIG : S_PRETRIG;
        end
      end
      S_PRETRIG: begin
        if (sample_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pre_len_q) state_d = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
`ifdef CAPTURE_FORCE_TRIG_EN
        if (force_trig) pend_d = 1'b1;
`endif
        if (sample_valid && trig_hit) begin
`ifdef CAPTURE_FORCE_TRIG_EN
          pend_d      = 1'b0;
`endif
          trig_addr_d = wr_ptr_q;
          post_cnt_d  = post_init;
          if (post_init == '0) begin
            start_ptr_d = wr_ptr_q - pre_len_q;
            state_d     = S_DONE;
          end else begin
            state_d     = S_POSTTRIG;
          end
        end
      end
      S_POSTTRIG: begin
        if (sample_valid) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == DEPTH_LOG2'(1)) begin
            start_ptr_d = trig_addr_q - pre_len_q;
            state_d     = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
`ifdef CAPTURE_FORCE_TRIG_EN
      pend_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      trig_addr_q  <= '0;
      pre_len_q    <= '0;
      cnt_q        <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      rd_data_q    <= '0;
`ifdef CAPTURE_FORCE_TRIG_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      trig_addr_q  <= trig_addr_d;
      pre_len_q    <= pre_len_d;
      cnt_q        <= cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      rd_data_q    <= mem[rd_phys];
`ifdef CAPTURE_FORCE_TRIG_EN
      pend_q       <= pend_d;
`endif
    end
  end

  // NOTE: the sample array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
  end

  assign rd_data = rd_data_q;
  assign state   = state_q;
  assign done    = (state_q == S_DONE);

endmodule

// File: doc/ds_capture_buffer.md
Name: ds_capture_buffer

Overview:
- Triggered snapshot buffer for the decimated ADC stream: consumes the downsampler output (16-bit signed sample plus its clock-enable strobe) on sys_clk.
- Keeps a circular pre-trigger history, detects a level crossing, fills post-trigger samples, then freezes the record.
- Software reads the frozen record through a random-access read port wired to CSRs.
- Sits directly downstream of the downsampler filter, in parallel with the DAC monitor path.

Parameters:
- DATA_W, 16, sample width (two's complement).
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_in  in  DATA_W  signed downsampled sample.
- sample_valid  in  1  sample qualifier; the downsampler ce_out, one cycle per sample.
- arm  in  1  single-cycle pulse that starts a capture.
- abort  in  1  single-cycle pulse that cancels a capture.
- trig_level  in  DATA_W  signed trigger threshold.
- trig_rising  in  1  1 = rising crossing, 0 = falling crossing.
- pretrig_len  in  DEPTH_LOG2  samples kept before the trigger sample; latched at arm.
- rd_addr  in  DEPTH_LOG2  read index relative to the oldest record sample.
- rd_data  out  DATA_W  record sample at rd_addr; registered.
- state  out  3  0 IDLE, 1 PRETRIG, 2 WAIT_TRIG, 3 POSTTRIG, 4 DONE.
- done  out  1  high while in DONE.

Behaviour:
- Reset (async assert, sync deassert internal): state=IDLE, done=0, rd_data=0, write pointer=0, start pointer=0, counters=0, prev-valid flag=0.
- Memory: DEPTH x DATA_W simple dual-port array, one write port and one read port, with no reset on contents.
- Write: only on a cycle with sample_valid=1 in PRETRIG, WAIT_TRIG or POSTTRIG; address = wr_ptr, after which wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- arm, accepted in IDLE or DONE only (ignored elsewhere):
  - latch pretrig_len, clamped to DEPTH-1;
  - clear the sample counter and prev-valid flag; done drops to 0;
  - next state is PRETRIG, or WAIT_TRIG if the latched pretrig_len=0.
  - A sample valid in the same cycle as arm is not captured.
- abort, in any state: next state IDLE, done=0. abort wins over a simultaneous arm.
- PRETRIG:
  - count valid samples written;
  - on the valid cycle that makes the count equal to pretrig_len, go to WAIT_TRIG.
  - No trigger evaluation in this state, but prev is updated.
- WAIT_TRIG:
  - every valid sample is written (history overwrites circularly).
  - Trigger on valid sample cur when prev_valid=1 and:
    - rising: prev < trig_level and cur >= trig_level;
    - falling: prev > trig_level and cur <= trig_level.
    - Comparisons are signed at full DATA_W.
  - On trigger, record trig_addr = wr_ptr (the address the trigger sample is written to), load post_cnt = DEPTH-1-pretrig_len, and go to POSTTRIG; if post_cnt=0, go directly to DONE.
- prev / prev_valid: updated on every valid sample in PRETRIG, WAIT_TRIG and POSTTRIG; held across invalid cycles, so any sample_valid gap pattern gives identical results.
- POSTTRIG:
  - each valid sample is written and decrements post_cnt;
  - the write that brings post_cnt to 0 moves to DONE on the next cycle.
  - Total record = pretrig_len + 1 + post samples = DEPTH.
- On entering DONE: start_ptr = (trig_addr - pretrig_len) mod DEPTH; writes stop; done=1; the record is held until the next arm.
- Read:
  - physical address = (start_ptr + rd_addr) mod DEPTH;
  - rd_data is updated every cycle with 1-cycle latency (rd_addr at cycle n gives the sample at cycle n+1).
  - Defined only in DONE; in other states it returns memory contents without guarantee.
  - rd_addr = pretrig_len is always the trigger sample.
- Reset mid-capture: immediate return to IDLE; memory contents are undefined for readout.

Optional Feature:
- Macro CAPTURE_FORCE_TRIG_EN.
- Defined: adds input port force_trig (1 bit, pulse). In WAIT_TRIG, force_trig sets a pending flag; the next valid sample is treated as the trigger sample regardless of level or prev_valid. The pending flag is cleared on arm, abort and trigger. force_trig is ignored in other states.
- Undefined: port absent; only level-crossing triggers exist.

Test Plan:
All scenarios use DEPTH_LOG2=4, DEPTH=16.
- Reset check: assert rst_n=0 mid-capture -> state=0, done=0, rd_data=0 asynchronously; arm after release works normally.
- Rising trigger: pretrig_len=4, trig_level=0, trig_rising=1, ramp -1000,-900,... step 100, sample_valid every cycle -> trigger on 0; done after 11 further samples; rd_addr 0..15 returns -400..1100.
- Falling trigger with gaps: sample_valid every 4th cycle, ramp 500 down by 100, trig_level=0, trig_rising=0, pretrig_len=2 -> rd_addr 2 = 0, rd_addr 0 = 200, rd_addr 15 = -1300; same result as contiguous valid.
- pretrig_len=0: arm goes straight to WAIT_TRIG, and the first sample cannot trigger even if already >= level -> rd_addr 0 = first crossing sample.
- Abort/arm: abort during POSTTRIG -> IDLE, done=0; arm+abort same cycle -> stays IDLE; arm while in POSTTRIG ignored; re-arm from IDLE captures fresh record.
- Clamp and wrap: pretrig_len=15, 40 samples before the trigger -> rd_addr 15 = trigger sample, rd_addr 0..14 = the 15 preceding samples, done immediately after the trigger write.
